// File: rtl/risc_mc_ctrl.sv
// rtl/risc_mc_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with memory-ready timeout
module risc_mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RET_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [3:0]       func,
  input  logic             a_zero,
  input  logic             a_neg,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic [2:0]       BranchOp,
  output logic             halted,
  output logic             err,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    RST_S, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR
  } state_t;

  localparam logic [5:0] OP_RALU = 6'd0;
  localparam logic [5:0] OP_IALU = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_BR   = 6'd4;
  localparam logic [5:0] OP_BMI  = 6'd5;
  localparam logic [5:0] OP_BPL  = 6'd6;
  localparam logic [5:0] OP_BZ   = 6'd7;
  localparam logic [5:0] OP_NOP  = 6'd8;
  localparam logic [5:0] OP_HALT = 6'd9;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       ret_inc;
  logic       is_ld;
  logic       taken;

  assign is_ld = (opcode == OP_LD);

  // branch condition from the A-register flags
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BR:   taken = 1'b1;
      OP_BMI:  taken = a_neg;
      OP_BPL:  taken = ~a_neg;
      OP_BZ:   taken = a_zero;
      default: taken = 1'b0;
    endcase
  end

  // state, wait counter and retired-instruction counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_S;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (ret_inc) retired <= retired + RET_W'(1);
    end
  end

  // next-state and control decode; wait counter clears unless a memory access keeps waiting
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    ret_inc     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = 4'd0;
    BranchOp    = 3'd0;
    halted      = 1'b0;
    err         = 1'b0;
    case (state)
      RST_S: state_nx = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = DECODE;
        end else if (wait_cnt == WAIT_LIM) begin
          state_nx = ERROR;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      DECODE: begin
        if (opcode <= OP_BZ) begin
          state_nx = EXEC;
        end else if (opcode == OP_NOP) begin
          state_nx = FETCH;
          ret_inc  = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_nx = HALT;
          ret_inc  = 1'b1;
        end else begin
          state_nx = ERROR;
        end
      end
      EXEC: begin
        case (opcode)
          OP_RALU: begin
            ALUOp    = func;
            state_nx = WB;
          end
          OP_IALU: begin
            ALUSrc   = 1'b1;
            ALUOp    = func;
            state_nx = WB;
          end
          OP_LD, OP_ST: begin
            ALUSrc   = 1'b1;
            state_nx = MEM;
          end
          OP_BR, OP_BMI, OP_BPL, OP_BZ: begin
            ALUSrc   = 1'b1;
            BranchOp = opcode[2:0] - 3'd3;
            pc_write = taken;
            pc_src   = taken;
            ret_inc  = 1'b1;
            state_nx = FETCH;
          end
          default: state_nx = ERROR;
        endcase
      end
      MEM: begin
        ALUSrc    = 1'b1;
        mem_read  = is_ld;
        mem_write = ~is_ld;
        if (mem_ready) begin
          if (is_ld) begin
            state_nx = WB;
          end else begin
            state_nx = FETCH;
            ret_inc  = 1'b1;
          end
        end else if (wait_cnt == WAIT_LIM) begin
          state_nx = ERROR;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        ALUSrc     = (opcode != OP_RALU);
        ALUOp      = is_ld ? 4'd0 : func;
        ret_inc    = 1'b1;
        state_nx   = FETCH;
      end
      HALT:    halted = 1'b1;
      ERROR:   err    = 1'b1;
      default: state_nx = ERROR;
    endcase
  end

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// tb/tb_risc_mc_ctrl.sv - randomized self-checking bench for risc_mc_ctrl against an instruction-level model
module tb_risc_mc_ctrl;

  typedef struct packed {
    logic       irw, pcw, pcs, rw, m2r, mr, mw, as;
    logic [3:0] aop;
    logic [2:0] bop;
    logic       hl, er;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [3:0]  func = '0;
  logic        a_zero = 1'b0, a_neg = 1'b0, mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg, mem_read, mem_write;
  logic        ALUSrc, halted, err;
  logic [3:0]  ALUOp;
  logic [2:0]  BranchOp;
  logic [31:0] retired;
  ctl_t        act;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret = '0;

  risc_mc_ctrl #(.MEM_WAIT_MAX(15), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .a_zero(a_zero), .a_neg(a_neg),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .BranchOp(BranchOp), .halted(halted), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  assign act = {ir_write, pc_write, pc_src, reg_write, mem_to_reg, mem_read, mem_write,
                ALUSrc, ALUOp, BranchOp, halted, err};

  // one clock cycle: apply mem_ready, check controls and retired mid-cycle, advance
  task automatic cyc(input string nm, input logic rdy, input ctl_t e);
    mem_ready = rdy;
    @(negedge clk);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s controls actual=%h expected=%h", nm, act, e);
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL %s retired actual=%0d expected=%0d", nm, retired, exp_ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (act !== '0 || retired !== '0) begin
      failures++;
      $display("FAIL in_reset actual=%h/%0d expected=0/0", act, retired);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;
    cyc("rst_s", 1'b1, '0);
  endtask

  // instruction-level model: expected control sequence for one instruction
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [3:0] fn,
                           input logic az, input logic an, input int wf, input int wm);
    ctl_t e;
    logic tk;
    opcode = op; func = fn; a_zero = az; a_neg = an;
    for (int i = 0; i < wf; i++) begin
      e = '0; e.mr = 1'b1;
      cyc({nm, "/fetch_wait"}, 1'b0, e);
    end
    e = '0; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    cyc({nm, "/fetch"}, 1'b1, e);
    cyc({nm, "/decode"}, 1'($urandom), '0);
    if (op == 6'd8) begin
      exp_ret++;
      return;
    end
    if (op == 6'd9) begin
      exp_ret++;
      for (int i = 0; i < 3; i++) begin
        e = '0; e.hl = 1'b1;
        cyc({nm, "/halted"}, 1'($urandom), e);
      end
      return;
    end
    if (op > 6'd9) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.er = 1'b1;
        cyc({nm, "/error"}, 1'($urandom), e);
      end
      return;
    end
    e = '0;
    case (op)
      6'd0, 6'd1: begin
        e.as = (op == 6'd1); e.aop = fn;
        cyc({nm, "/exec"}, 1'($urandom), e);
        e.rw = 1'b1;
        cyc({nm, "/wb"}, 1'($urandom), e);
        exp_ret++;
      end
      6'd2, 6'd3: begin
        e.as = 1'b1;
        cyc({nm, "/exec"}, 1'($urandom), e);
        e.mr = (op == 6'd2); e.mw = (op == 6'd3);
        for (int i = 0; i < wm; i++) cyc({nm, "/mem_wait"}, 1'b0, e);
        cyc({nm, "/mem"}, 1'b1, e);
        if (op == 6'd2) begin
          e.mr = 1'b0; e.rw = 1'b1; e.m2r = 1'b1;
          cyc({nm, "/wb"}, 1'($urandom), e);
        end
        exp_ret++;
      end
      default: begin
        tk = (op == 6'd4) || (op == 6'd5 && an) || (op == 6'd6 && !an) || (op == 6'd7 && az);
        case (op)
          6'd4:    e.bop = 3'd1;
          6'd5:    e.bop = 3'd2;
          6'd6:    e.bop = 3'd3;
          default: e.bop = 3'd4;
        endcase
        e.as = 1'b1; e.pcw = tk; e.pcs = tk;
        cyc({nm, "/exec"}, 1'($urandom), e);
        exp_ret++;
      end
    endcase
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu();
    run_instr("ralu", 6'd0, 4'd5, 1'b0, 1'b0, 0, 0);
    run_instr("ialu", 6'd1, 4'd9, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_mem();
    run_instr("ld_wait3", 6'd2, 4'd3, 1'b0, 1'b0, 0, 3);
    run_instr("st", 6'd3, 4'd7, 1'b0, 1'b0, 0, 0);
    run_instr("ld_wait15", 6'd2, 4'd1, 1'b0, 1'b0, 0, 15);
  endtask

  task automatic test_branch();
    run_instr("bz_taken", 6'd7, 4'd0, 1'b1, 1'b0, 0, 0);
    run_instr("bz_not", 6'd7, 4'd0, 1'b0, 1'b1, 0, 0);
    run_instr("bmi_taken", 6'd5, 4'd0, 1'b0, 1'b1, 0, 0);
    run_instr("bpl_not", 6'd6, 4'd0, 1'b1, 1'b1, 0, 0);
    run_instr("br", 6'd4, 4'd0, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_timeout();
    ctl_t e;
    do_reset();
    opcode = 6'd0;
    for (int i = 0; i < 16; i++) begin
      e = '0; e.mr = 1'b1;
      cyc("timeout_wait", 1'b0, e);
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e.er = 1'b1;
      cyc("timeout_err", 1'($urandom), e);
    end
    do_reset();
    run_instr("timeout_edge", 6'd1, 4'd2, 1'b0, 1'b0, 15, 0);
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr("illegal12", 6'd12, 4'd0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_halt();
    do_reset();
    run_instr("nop", 6'd8, 4'd0, 1'b0, 1'b0, 0, 0);
    run_instr("halt", 6'd9, 4'd0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    ctl_t e;
    do_reset();
    run_instr("rm_nop", 6'd8, 4'd0, 1'b0, 1'b0, 0, 0);
    opcode = 6'd3; func = 4'd0;
    e = '0; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    cyc("rm_fetch", 1'b1, e);
    cyc("rm_decode", 1'b0, '0);
    e = '0; e.as = 1'b1;
    cyc("rm_exec", 1'b0, e);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      failures++;
      $display("FAIL rm_mem_write actual=%b expected=1", mem_write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (act !== '0 || retired !== '0) begin
      failures++;
      $display("FAIL rm_async actual=%h/%0d expected=0/0", act, retired);
    end
    do_reset();
    e = '0; e.mr = 1'b1;
    cyc("rm_fetch_after", 1'b0, e);
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] op;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = 6'($urandom_range(0, 8));
      run_instr("rand", op, 4'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_mc_ctrl.md
Name: risc_mc_ctrl

Overview:
- Multi-cycle control FSM for the RISC core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU operand-select controls (BranchOp, ALUSrc, ALUOp) plus PC, IR, register-file and memory enables.
- Sits between the IR/flag outputs of the datapath and the ALU input-select and memory logic. Handles a memory ready handshake with timeout.

Parameters:
MEM_WAIT_MAX, 15, max cycles a FETCH/MEM access may wait for mem_ready before entering ERROR (1..255)
RET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
opcode  input  6  IR[31:26]; held stable by datapath from DECODE until next fetch completes
func  input  4  IR[3:0], ALU function for R/I-type
a_zero  input  1  register A == 0
a_neg  input  1  register A[31]
mem_ready  input  1  memory completes current access this cycle
ir_write  output  1  load IR
pc_write  output  1  load PC
pc_src  output  1  0: PC<=NPC (PC+4), 1: PC<=ALU result
reg_write  output  1  register-file write
mem_to_reg  output  1  writeback selects LMD
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ALUSrc  output  1  0: ALU in2 = B, 1: imm
ALUOp  output  4  ALU function (0 = ADD)
BranchOp  output  3  0 none, 1 BR, 2 BMI, 3 BPL, 4 BZ; nonzero makes ALU in1 = NPC
halted  output  1  HALT executed
err  output  1  illegal opcode or memory timeout
retired  output  RET_W  count of completed instructions

Behaviour:
- Opcodes: 0 R-ALU, 1 I-ALU, 2 LD, 3 ST, 4 BR, 5 BMI, 6 BPL, 7 BZ, 8 NOP, 9 HALT, others illegal.
- States: RST_S, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR (3-bit register).
- While rst is high or in RST_S: all outputs 0, wait counter 0, retired 0. RST_S moves to FETCH unconditionally next cycle.
- FETCH:
  - mem_read=1.
  - When mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0, next DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1 cycle):
  - Opcodes 0-7 go to EXEC.
  - NOP goes to FETCH and increments retired.
  - HALT goes to HALT and increments retired.
  - Illegal opcode goes to ERROR.
- EXEC:
  - R-ALU: ALUSrc=0, ALUOp=func, next WB.
  - I-ALU: ALUSrc=1, ALUOp=func, next WB.
  - LD/ST: ALUSrc=1, ALUOp=0, next MEM.
  - Branches: ALUSrc=1, ALUOp=0, BranchOp=opcode-3.
    - Taken conditions: BR always; BMI a_neg; BPL !a_neg; BZ a_zero.
    - If taken: pc_write=1, pc_src=1.
    - Next FETCH; retired increments.
- MEM:
  - LD asserts mem_read; ST asserts mem_write.
  - ALUSrc=1 and ALUOp=0 held.
  - On mem_ready: LD goes to WB; ST goes to FETCH and increments retired.
  - Otherwise wait and increment the counter.
- WB:
  - reg_write=1, next FETCH, retired increments.
  - mem_to_reg=1 for LD, 0 for ALU ops.
  - ALUOp/ALUSrc hold their EXEC values.
- Wait counter:
  - Clears on any transition out of FETCH/MEM.
  - If the counter equals MEM_WAIT_MAX while mem_ready=0, next state is ERROR.
  - mem_ready in that same cycle wins: the access completes normally.
- HALT: halted=1, all enables 0. ERROR: err=1, all enables 0. Both are held until rst.
- Output decoding:
  - ir_write and pc_write are Mealy, depending on mem_ready/flags.
  - All other outputs are Moore, decoded from state and the stable IR fields.
  - In states where a control is not listed, it is 0.
- retired wraps modulo 2^RET_W.
- rst asserted mid-instruction: immediate return to RST_S with all outputs 0. No partial write is issued after the reset edge.

Test Plan:
- Reset release, mem_ready=1 always, R-ALU opcode 0, func 5 -> FETCH (ir_write, pc_write, pc_src=0), DECODE, EXEC (ALUSrc=0, ALUOp=5), WB (reg_write=1, mem_to_reg=0); retired=1 after 4 cycles.
- LD with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1; ST with mem_ready=1 -> mem_write 1 cycle, no WB, retired+1.
- BZ with a_zero=1 -> EXEC BranchOp=4, ALUSrc=1, pc_write=1, pc_src=1. BZ with a_zero=0 -> BranchOp=4, pc_write=0. BMI with a_neg=1 -> taken.
- MEM_WAIT_MAX=15, mem_ready held 0 in FETCH -> ERROR after 16 FETCH cycles, err=1 held. Ready asserted on the 16th cycle -> normal DECODE instead.
- Opcode 12 at DECODE -> ERROR, err=1. Opcode 9 -> halted=1, retired+1, no further mem_read.
- Assert rst during MEM of an ST with mem_ready=0 -> mem_write drops immediately, retired=0. After release, RST_S for one cycle, then FETCH.
